// File: rtl/core_mem_ctrl_pkg.sv
// rtl/core_mem_ctrl_pkg.sv - shared defaults, cycle phase type and parity helper for the core memory controller
package core_mem_ctrl_pkg;

    localparam int DEF_DW        = 12;
    localparam int DEF_AW        = 15;
    localparam int DEF_PARITY    = 1;
    localparam int DEF_T_READ    = 6;
    localparam int DEF_T_STB     = 10;
    localparam int DEF_T_STB_LEN = 2;
    localparam int DEF_T_WR      = 16;
    localparam int DEF_T_DONE    = 29;

    // widest data word the parity helper accepts; callers zero-extend into it
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_BUSY,
        PH_DONE
    } cycle_phase_e;

    // odd parity: the stored bit makes the total count of ones odd
    function automatic logic odd_parity(input logic [MAX_W-1:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/core_mem_array.sv
// rtl/core_mem_array.sv - word array with one registered read port and one write port
module core_mem_array
    import core_mem_ctrl_pkg::*;
#(
    parameter int W  = DEF_DW + DEF_PARITY,
    parameter int AW = DEF_AW
) (
    input  logic          clk_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i
);

    logic [W-1:0] mem_q [0:(1<<AW)-1];
    logic [W-1:0] rdata_q;

    // array contents are never reset; read is registered every clock
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/core_mem_ctrl.sv
// rtl/core_mem_ctrl.sv - timed core-memory cycle emulator: read, strobe, restore/write, done
module core_mem_ctrl
    import core_mem_ctrl_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int AW        = DEF_AW,
    parameter int PARITY    = DEF_PARITY,
    parameter int T_READ    = DEF_T_READ,
    parameter int T_STB     = DEF_T_STB,
    parameter int T_STB_LEN = DEF_T_STB_LEN,
    parameter int T_WR      = DEF_T_WR,
    parameter int T_DONE    = DEF_T_DONE
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mem_start,
    input  logic [AW-1:0] addr,
    input  logic          wr_en,
    input  logic [DW-1:0] data_in,
    input  logic          clr_err,
    output logic [DW-1:0] data_out,
    output logic          strobe_n,
    output logic          mem_done_n,
    output logic          busy,
    output logic          parity_err,
    output logic          overrun
);

    localparam int TW = $clog2(T_DONE + 1);
    localparam int WW = DW + PARITY;

    localparam logic [TW-1:0] TM_ONE     = TW'(1);
    localparam logic [TW-1:0] TM_READ    = TW'(T_READ);
    localparam logic [TW-1:0] TM_STB     = TW'(T_STB);
    localparam logic [TW-1:0] TM_STB_END = TW'(T_STB + T_STB_LEN);
    localparam logic [TW-1:0] TM_WR      = TW'(T_WR);
    localparam logic [TW-1:0] TM_DONE    = TW'(T_DONE);

    logic [TW-1:0] timer_q, timer_d;
    logic          prev_q;
    logic [AW-1:0] addr_q;
    logic [WW-1:0] rd_hold_q;
    logic [WW-1:0] wword_q, wword_d;
    logic [WW-1:0] wr_word;
    logic [WW-1:0] rdata;
    logic [DW-1:0] data_out_q;
    logic          strobe_n_q, done_n_q, busy_q, perr_q, ovr_q;

    logic          start_edge, in_cycle, accept, ovr_set, perr_set, we;
    cycle_phase_e  phase_d;

    // a written word carries freshly computed parity; without parity it is the raw data
    if (PARITY != 0) begin : g_par
        assign wr_word = {odd_parity(MAX_W'(data_in)), data_in};
    end else begin : g_nopar
        assign wr_word = data_in;
    end

    // edge detect, timer advance, phase decode and write-window decode
    always_comb begin
        start_edge = mem_start & ~prev_q;
        in_cycle   = (timer_q != '0) && (timer_q < TM_DONE);
        accept     = start_edge & ~in_cycle;
        ovr_set    = start_edge & in_cycle;
        perr_set   = (PARITY != 0) && (timer_q == TM_READ) && !(^rdata);
        we         = (timer_q > TM_WR) && (timer_q < TM_DONE);
        // restore puts back the whole read word, parity bit included, so a bad word stays bad
        wword_d    = wr_en ? wr_word : rd_hold_q;

        timer_d = timer_q;
        if (accept) begin
            timer_d = TM_ONE;
        end else if (in_cycle) begin
            timer_d = timer_q + TM_ONE;
        end

        phase_d = PH_IDLE;
        if (timer_d >= TM_DONE) begin
            phase_d = PH_DONE;
        end else if (timer_d != '0) begin
            phase_d = PH_BUSY;
        end
    end

    // timer, start history, registered status outputs and sticky flags; set beats clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q    <= '0;
            prev_q     <= 1'b1;
            data_out_q <= '0;
            strobe_n_q <= 1'b1;
            done_n_q   <= 1'b1;
            busy_q     <= 1'b0;
            perr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            prev_q     <= mem_start;
            strobe_n_q <= !((timer_d >= TM_STB) && (timer_d < TM_STB_END));
            done_n_q   <= (phase_d != PH_DONE);
            busy_q     <= (phase_d == PH_BUSY);
            if (timer_q == TM_READ) begin
                data_out_q <= rdata[DW-1:0];
            end
            perr_q <= perr_set | (perr_q & ~clr_err);
            ovr_q  <= ovr_set | (ovr_q & ~clr_err);
        end
    end

    // address, read word and write word latches; pure datapath, no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= addr;
        end
        if (timer_q == TM_READ) begin
            rd_hold_q <= rdata;
        end
        if (timer_q == TM_WR) begin
            wword_q <= wword_d;
        end
    end

    core_mem_array #(
        .W  (WW),
        .AW (AW)
    ) u_array (
        .clk_i   (clk),
        .raddr_i (addr_q),
        .rdata_o (rdata),
        .we_i    (we),
        .waddr_i (addr_q),
        .wdata_i (wword_q)
    );

    assign data_out   = data_out_q;
    assign strobe_n   = strobe_n_q;
    assign mem_done_n = done_n_q;
    assign busy       = busy_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_core_mem_ctrl.sv
// tb/tb_core_mem_ctrl.sv - scoreboard bench for core_mem_ctrl, default and reduced-timing instances
module tb_core_mem_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // unit 0: default parameters
    logic        ms0 = 1'b0, wr0 = 1'b0, clr0 = 1'b0;
    logic [14:0] a0 = '0;
    logic [11:0] d0 = '0;
    logic [11:0] q0;
    logic        stb0, dn0, bz0, pe0, ov0;

    // unit 1: 16-bit data, no parity, short timing
    logic        ms1 = 1'b0, wr1 = 1'b0, clr1 = 1'b0;
    logic [7:0]  a1 = '0;
    logic [15:0] d1 = '0;
    logic [15:0] q1;
    logic        stb1, dn1, bz1, pe1, ov1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int unit;
        int data;       // -1: old array content, not checked
        int perr;       // -1: not checked
        int ovr;
        int rd_cnt;     // first sample after the T_READ edge
        int stb_first;
        int stb_len;
        int done_cnt;
    } exp_t;

    exp_t sb_q[$];

    core_mem_ctrl dut0 (
        .clk(clk), .rst_n(rst_n), .mem_start(ms0), .addr(a0), .wr_en(wr0),
        .data_in(d0), .clr_err(clr0), .data_out(q0), .strobe_n(stb0),
        .mem_done_n(dn0), .busy(bz0), .parity_err(pe0), .overrun(ov0)
    );

    core_mem_ctrl #(
        .DW(16), .AW(8), .PARITY(0), .T_READ(3), .T_STB(4), .T_STB_LEN(2), .T_WR(8), .T_DONE(12)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_start(ms1), .addr(a1), .wr_en(wr1),
        .data_in(d1), .clr_err(clr1), .data_out(q1), .strobe_n(stb1),
        .mem_done_n(dn1), .busy(bz1), .parity_err(pe1), .overrun(ov1)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endfunction

    // hand-derived cycle timing for each unit
    function automatic void expect_cycle(input int u, input int data, input int perr, input int ovr);
        exp_t e;
        e.unit = u;
        e.data = data;
        e.perr = perr;
        e.ovr  = ovr;
        if (u == 0) begin
            e.rd_cnt = 7;  e.stb_first = 10; e.stb_len = 2; e.done_cnt = 29;
        end else begin
            e.rd_cnt = 4;  e.stb_first = 4;  e.stb_len = 2; e.done_cnt = 12;
        end
        sb_q.push_back(e);
    endfunction

    // monitor: counts clocks from busy rising, records strobe and read data, scores at done
    int   m_cnt [2] = '{0, 0};
    int   m_sf  [2] = '{0, 0};
    int   m_sl  [2] = '{0, 0};
    int   m_rd  [2] = '{0, 0};
    int   m_pb  [2] = '{0, 0};
    int   m_pd  [2] = '{1, 1};

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int   b, s, dn, p, o, dq;
            exp_t e;
            b  = (g == 0) ? int'(bz0)  : int'(bz1);
            s  = (g == 0) ? int'(stb0) : int'(stb1);
            dn = (g == 0) ? int'(dn0)  : int'(dn1);
            p  = (g == 0) ? int'(pe0)  : int'(pe1);
            o  = (g == 0) ? int'(ov0)  : int'(ov1);
            dq = (g == 0) ? int'(q0)   : int'(q1);
            if (b != 0 && m_pb[g] == 0) begin
                m_cnt[g] = 1; m_sf[g] = 0; m_sl[g] = 0; m_rd[g] = -1;
            end else if (!rst_n || (b == 0 && dn != 0)) begin
                m_cnt[g] = 0;
            end else if (m_cnt[g] != 0) begin
                m_cnt[g]++;
            end
            if (m_cnt[g] != 0 && s == 0) begin
                if (m_sl[g] == 0) m_sf[g] = m_cnt[g];
                m_sl[g]++;
            end
            if (m_cnt[g] != 0 && sb_q.size() != 0 && m_cnt[g] == sb_q[0].rd_cnt) begin
                m_rd[g] = dq;
            end
            if (m_cnt[g] != 0 && dn == 0 && m_pd[g] != 0) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", g, -1);
                end else begin
                    e = sb_q.pop_front();
                    chk("unit", g, e.unit);
                    if (e.data >= 0) chk("data_out", m_rd[g], e.data);
                    if (e.perr >= 0) chk("parity_err", p, e.perr);
                    chk("overrun", o, e.ovr);
                    chk("strobe_first", m_sf[g], e.stb_first);
                    chk("strobe_len", m_sl[g], e.stb_len);
                    chk("done_clock", m_cnt[g], e.done_cnt);
                end
                m_cnt[g] = 0;
            end
            m_pb[g] = b;
            m_pd[g] = dn;
        end
    end

    task automatic wait_done(input int u);
        int n = 0;
        while (((u == 0) ? dn0 : dn1) != 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cycle_done", (u == 0) ? int'(dn0) : int'(dn1), 0);
        @(negedge clk);
    endtask

    task automatic run_cycle(input int u, input int a, input int w, input int d);
        @(negedge clk);
        if (u == 0) begin
            a0 = a[14:0]; wr0 = w[0]; d0 = d[11:0]; ms0 = 1'b1;
        end else begin
            a1 = a[7:0];  wr1 = w[0]; d1 = d[15:0]; ms1 = 1'b1;
        end
        @(negedge clk);
        // address is latched at the start edge, so scrambling it now must not matter
        if (u == 0) begin
            ms0 = 1'b0; a0 = ~a0;
        end else begin
            ms1 = 1'b0; a1 = ~a1;
        end
        wait_done(u);
    endtask

    task automatic wait_cnt(input int u, input int n);
        int k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (m_cnt[u] != n && k < 200);
        chk("wait_cnt", m_cnt[u], n);
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset release while mem_start is already high: no cycle may start
        ms0 = 1'b1; ms1 = 1'b1; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_busy",     int'(bz0),  0);
        chk("rst_done_n",   int'(dn0),  1);
        chk("rst_strobe_n", int'(stb0), 1);
        chk("rst_perr",     int'(pe0),  0);
        chk("rst_ovr",      int'(ov0),  0);
        chk("rst_data",     int'(q0),   0);
        chk("rst_busy1",    int'(bz1),  0);
        ms0 = 1'b0; ms1 = 1'b0;
        @(negedge clk);

        // write 5252 to 07777, then two read-restores of it
        expect_cycle(0, -1, -1, 0);
        run_cycle(0, 'o7777, 1, 'o5252);
        clr_pulse();
        expect_cycle(0, 'o5252, 0, 0);
        run_cycle(0, 'o7777, 0, 'o1234);
        expect_cycle(0, 'o5252, 0, 0);
        run_cycle(0, 'o7777, 0, 0);

        // even-parity word planted at 00200: flagged on every read, data still delivered
        @(negedge clk);
        dut0.u_array.mem_q[15'o00200] <= 13'h0003;
        @(negedge clk);
        expect_cycle(0, 'o0003, 1, 0);
        run_cycle(0, 'o200, 0, 0);
        clr_pulse();
        chk("perr_clear", int'(pe0), 0);
        expect_cycle(0, 'o0003, 1, 0);
        run_cycle(0, 'o200, 0, 0);
        clr_pulse();
        chk("perr_clear2", int'(pe0), 0);

        // second start edge at timer 20 is ignored and flagged
        expect_cycle(0, 'o5252, 0, 1);
        fork
            run_cycle(0, 'o7777, 0, 0);
            begin
                wait_cnt(0, 20);
                ms0 = 1'b1;
                @(negedge clk);
                ms0 = 1'b0;
            end
        join
        expect_cycle(0, 'o5252, 0, 1);
        run_cycle(0, 'o7777, 0, 0);
        clr_pulse();
        chk("ovr_clear", int'(ov0), 0);

        // reset at timer 18 of a write of 7777: async clear, word already written
        @(negedge clk);
        a0 = 15'o00100; wr0 = 1'b1; d0 = 12'o7777; ms0 = 1'b1;
        @(negedge clk);
        ms0 = 1'b0;
        wait_cnt(0, 18);
        rst_n = 1'b0;
        #1;
        chk("arst_busy",     int'(bz0),  0);
        chk("arst_done_n",   int'(dn0),  1);
        chk("arst_strobe_n", int'(stb0), 1);
        chk("arst_data",     int'(q0),   0);
        chk("arst_perr",     int'(pe0),  0);
        chk("arst_ovr",      int'(ov0),  0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_cycle(0, 'o7777, 0, 0);
        run_cycle(0, 'o100, 0, 0);

        // reduced-timing 16-bit unit without parity
        expect_cycle(1, -1, 0, 0);
        run_cycle(1, 'hFF, 1, 'hA5C3);
        expect_cycle(1, 'hA5C3, 0, 0);
        run_cycle(1, 'hFF, 0, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
